// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - two-stage valid/ready ALU with a Z/V/N flag register committed on result accept
module pipelined_alu #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int NLANE = WIDTH / LANE_W;
    localparam int NBYTE = WIDTH / 8;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1: captured operands
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_op_q;

    // Stage 2: computed result plus what the flags should do on accept
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_err_q;
    logic             s2_upd_z_q;
    logic             s2_upd_vn_q;
    logic             s2_sat_q;

    logic flag_z_q, flag_v_q, flag_n_q;

    logic             s2_en, s1_en, out_accept;
    logic [WIDTH-1:0] res_d;
    logic             err_d, upd_z_d, upd_vn_d, sat_d;

    logic [WIDTH-1:0]        sum_w, diff_w, sra_w, ror_w, mem_w, red_w, padd_w;
    logic signed [WIDTH-1:0] a_s;
    logic [SH_W-1:0]         sh;
    logic [SH_W:0]           ror_sh;
    logic                    add_ovf, sub_ovf;
    logic [WIDTH-1:0]        sat_val;
    logic [LANE_W-1:0]       la, lb, ls;

    assign s2_en      = !s2_valid_q || out_ready;
    assign s1_en      = !s1_valid_q || s2_en;
    assign in_ready   = s1_en;
    assign out_accept = s2_valid_q && out_ready;

    assign sum_w   = s1_a_q + s1_b_q;
    assign diff_w  = s1_a_q - s1_b_q;
    assign add_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
    assign sub_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff_w[WIDTH-1] != s1_a_q[WIDTH-1]);
    assign sat_val = s1_a_q[WIDTH-1] ? SMIN : SMAX;

    assign sh     = s1_b_q[SH_W-1:0];
    assign a_s    = s1_a_q;
    assign sra_w  = a_s >>> sh;
    // A zero rotate makes ror_sh equal WIDTH, which shifts the wrap term out entirely
    assign ror_sh = (SH_W+1)'(WIDTH) - {1'b0, sh};
    assign ror_w  = (s1_a_q >> sh) | (s1_a_q << ror_sh);
    assign mem_w  = {s1_a_q[WIDTH-1:1], 1'b0} + {s1_b_q[WIDTH-2:0], 1'b0};

    always_comb begin
        red_w  = '0;
        padd_w = '0;
        la     = '0;
        lb     = '0;
        ls     = '0;
        for (int i = 0; i < NBYTE; i++) begin
            red_w = red_w + {{(WIDTH-8){s1_a_q[8*i+7]}}, s1_a_q[8*i +: 8]}
                          + {{(WIDTH-8){s1_b_q[8*i+7]}}, s1_b_q[8*i +: 8]};
        end
        for (int l = 0; l < NLANE; l++) begin
            la = s1_a_q[l*LANE_W +: LANE_W];
            lb = s1_b_q[l*LANE_W +: LANE_W];
            ls = la + lb;
            if ((la[LANE_W-1] == lb[LANE_W-1]) && (ls[LANE_W-1] != la[LANE_W-1])) begin
                ls = la[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
            end
            padd_w[l*LANE_W +: LANE_W] = ls;
        end
    end

    always_comb begin
        res_d    = '0;
        err_d    = 1'b0;
        upd_z_d  = 1'b0;
        upd_vn_d = 1'b0;
        sat_d    = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                upd_z_d  = 1'b1;
                upd_vn_d = 1'b1;
                sat_d    = add_ovf;
                res_d    = add_ovf ? sat_val : sum_w;
            end
            OP_SUB: begin
                upd_z_d  = 1'b1;
                upd_vn_d = 1'b1;
                sat_d    = sub_ovf;
                res_d    = sub_ovf ? sat_val : diff_w;
            end
            OP_XOR: begin
                upd_z_d = 1'b1;
                res_d   = s1_a_q ^ s1_b_q;
            end
            OP_RED:    res_d = red_w;
            OP_SLL: begin
                upd_z_d = 1'b1;
                res_d   = s1_a_q << sh;
            end
            OP_SRA: begin
                upd_z_d = 1'b1;
                res_d   = sra_w;
            end
            OP_ROR: begin
                upd_z_d = 1'b1;
                res_d   = ror_w;
            end
            OP_PADDSB: res_d = padd_w;
            OP_LW:     res_d = mem_w;
            OP_SW:     res_d = mem_w;
            OP_LLB:    res_d = {s1_a_q[WIDTH-1:8], s1_b_q[7:0]};
            OP_LHB:    res_d = {s1_b_q[7:0], s1_a_q[WIDTH-9:0]};
            default:   err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_err_q    <= 1'b0;
            s2_upd_z_q  <= 1'b0;
            s2_upd_vn_q <= 1'b0;
            s2_sat_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_n_q    <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                if (s1_en) s1_valid_q <= in_valid;
                if (s2_en) s2_valid_q <= s1_valid_q;
            end
            if (s1_en && in_valid && !flush) begin
                s1_a_q  <= in_a;
                s1_b_q  <= in_b;
                s1_op_q <= in_op;
            end
            if (s2_en && s1_valid_q && !flush) begin
                s2_data_q   <= res_d;
                s2_err_q    <= err_d;
                s2_upd_z_q  <= upd_z_d;
                s2_upd_vn_q <= upd_vn_d;
                s2_sat_q    <= sat_d;
            end
            // A flushed result is never committed, even if the consumer took it that cycle
            if (out_accept && !flush) begin
                if (s2_upd_z_q) flag_z_q <= (s2_data_q == '0);
                if (s2_upd_vn_q) begin
                    flag_v_q <= s2_sat_q;
                    flag_n_q <= s2_data_q[WIDTH-1];
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_err   = s2_err_q;
    assign flag_z    = flag_z_q;
    assign flag_v    = flag_v_q;
    assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// tb/tb_pipelined_alu.sv - randomized and directed checks of pipelined_alu against a behavioural model
module tb_pipelined_alu;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic        flag_z, flag_v, flag_n;
    logic [15:0] in_a, in_b, out_data;
    logic [3:0]  in_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(16), .LANE_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } txn_t;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
        logic        zu;
        logic        vnu;
        logic        v;
    } res_t;

    txn_t        q[$];
    logic        mz = 0, mv = 0, mn = 0;
    logic        obs_in_hs, obs_out_hs, obs_in_ready, obs_out_valid, obs_err;
    logic [15:0] obs_data;
    logic        exp_avail, exp_err;
    logic [15:0] exp_data;

    function automatic res_t ref_alu(logic [15:0] a, logic [15:0] b, logic [3:0] op);
        res_t        r;
        int          sa, sb, ua, ub, s, sh, x, y;
        logic [15:0] d;
        r  = '0;
        d  = '0;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        sh = b[3:0];
        case (op)
            4'h0, 4'h1: begin
                s = (op == 4'h0) ? sa + sb : sa - sb;
                r.zu = 1; r.vnu = 1;
                if (s > 32767)       begin s = 32767;  r.v = 1; end
                else if (s < -32768) begin s = -32768; r.v = 1; end
                d = s[15:0];
            end
            4'h2: begin r.zu = 1; d = a ^ b; end
            4'h3: begin
                s = 0;
                for (int k = 0; k < 2; k++) begin
                    x = $signed(a[8*k +: 8]);
                    y = $signed(b[8*k +: 8]);
                    s = s + x + y;
                end
                d = s[15:0];
            end
            4'h4: begin r.zu = 1; s = ua << sh; d = s[15:0]; end
            4'h5: begin r.zu = 1; s = sa >>> sh; d = s[15:0]; end
            4'h6: begin r.zu = 1; s = (ua >> sh) | (ua << (16 - sh)); d = s[15:0]; end
            4'h7: begin
                for (int l = 0; l < 4; l++) begin
                    x = $signed(a[4*l +: 4]);
                    y = $signed(b[4*l +: 4]);
                    s = x + y;
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    d[4*l +: 4] = s[3:0];
                end
            end
            4'h8, 4'h9: begin s = (ua & 32'hFFFE) + 2 * ub; d = s[15:0]; end
            4'hA: d = {a[15:8], b[7:0]};
            4'hB: d = {b[7:0], a[7:0]};
            default: r.e = 1;
        endcase
        r.d = d;
        return r;
    endfunction

    // One clock: sample at the falling edge, then advance the model past the rising edge
    task automatic step();
        res_t r;
        txn_t t;
        r = '0;
        @(negedge clk);
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_in_hs     = in_valid && in_ready;
        obs_out_hs    = out_valid && out_ready;
        obs_data      = out_data;
        obs_err       = out_err;
        exp_avail     = (q.size() > 0);
        if (exp_avail) begin
            r        = ref_alu(q[0].a, q[0].b, q[0].op);
            exp_data = r.d;
            exp_err  = r.e;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            mz = 0; mv = 0; mn = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (obs_out_hs && exp_avail) begin
                if (r.zu) mz = (r.d == 16'h0);
                if (r.vnu) begin mv = r.v; mn = r.d[15]; end
                void'(q.pop_front());
            end
            if (obs_in_hs) begin
                t.a = in_a; t.b = in_b; t.op = in_op;
                q.push_back(t);
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                          output logic [15:0] d, output logic e, output int lat);
        logic got;
        in_a = a; in_b = b; in_op = op; in_valid = 1; out_ready = 1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (obs_in_hs) break;
        end
        in_valid = 0;
        lat = 0; got = 0; d = 16'hxxxx; e = 1'bx;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            lat++;
            if (obs_out_hs) begin got = 1; d = obs_data; e = obs_err; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL run_op_timeout op=%0h got no result, required one", op);
        end
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_a = '0; in_b = '0; in_op = '0;
        step(); step();
        checks++;
        if ({out_valid, out_data, out_err, flag_z, flag_v, flag_n} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b zvn=%b%b%b required all 0",
                     out_valid, out_data, out_err, flag_z, flag_v, flag_n);
        end
        rst = 0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_arith();
        logic [15:0] d; logic e; int lat;
        run_op(16'h7000, 16'h2000, 4'h0, d, e, lat);
        checks++;
        if (d !== 16'h7FFF) begin errors++; $display("FAIL add_sat got %h required 7fff", d); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL latency got %0d required 2", lat); end
        checks++;
        if ({flag_z, flag_v, flag_n} !== 3'b010) begin
            errors++; $display("FAIL add_sat_flags got %b%b%b required 010", flag_z, flag_v, flag_n);
        end
        run_op(16'h0005, 16'h0005, 4'h1, d, e, lat);
        checks++;
        if (d !== 16'h0000 || {flag_z, flag_v, flag_n} !== 3'b100) begin
            errors++; $display("FAIL sub_zero got %h zvn=%b%b%b required 0000 100", d, flag_z, flag_v, flag_n);
        end
        run_op(16'h00FF, 16'h00F0, 4'h2, d, e, lat);
        checks++;
        if (d !== 16'h000F || {flag_z, flag_v, flag_n} !== 3'b000) begin
            errors++; $display("FAIL xor got %h zvn=%b%b%b required 000f 000", d, flag_z, flag_v, flag_n);
        end
    endtask

    task automatic test_lanes_shifts();
        logic [15:0] d; logic e; int lat;
        // 4-bit lanes: 7+1 saturates to 7, -1+1=0, 1+7 saturates to 7, -8+-8 saturates to -8
        run_op(16'h7F18, 16'h1178, 4'h7, d, e, lat);
        checks++;
        if (d !== 16'h7078) begin errors++; $display("FAIL paddsb got %h required 7078", d); end
        run_op(16'h8000, 16'h0004, 4'h5, d, e, lat);
        checks++;
        if (d !== 16'hF800) begin errors++; $display("FAIL sra got %h required f800", d); end
        run_op(16'h0001, 16'h0001, 4'h6, d, e, lat);
        checks++;
        if (d !== 16'h8000) begin errors++; $display("FAIL ror got %h required 8000", d); end
        run_op(16'h1234, 16'h0010, 4'h6, d, e, lat);
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL ror_zero got %h required 1234", d); end
        run_op(16'h0003, 16'h0004, 4'h4, d, e, lat);
        checks++;
        if (d !== 16'h0030 || flag_z !== 1'b0) begin errors++; $display("FAIL sll got %h z=%b required 0030 0", d, flag_z); end
    endtask

    task automatic test_misc_ops();
        logic [15:0] d; logic e; int lat;
        run_op(16'h8000, 16'h0001, 4'h1, d, e, lat);
        checks++;
        if (d !== 16'h8000 || {flag_z, flag_v, flag_n} !== 3'b011) begin
            errors++; $display("FAIL sub_sat got %h zvn=%b%b%b required 8000 011", d, flag_z, flag_v, flag_n);
        end
        run_op(16'h1234, 16'h5678, 4'hE, d, e, lat);
        checks++;
        if (d !== 16'h0000 || e !== 1'b1 || {flag_z, flag_v, flag_n} !== 3'b011) begin
            errors++; $display("FAIL illegal got d=%h e=%b zvn=%b%b%b required 0000 1 011", d, e, flag_z, flag_v, flag_n);
        end
        run_op(16'h1001, 16'h0004, 4'h8, d, e, lat);
        checks++;
        if (d !== 16'h1008 || e !== 1'b0) begin errors++; $display("FAIL lw got %h e=%b required 1008 0", d, e); end
        run_op(16'h1234, 16'h00AB, 4'hB, d, e, lat);
        checks++;
        if (d !== 16'hAB34) begin errors++; $display("FAIL lhb got %h required ab34", d); end
        run_op(16'h1234, 16'h56AB, 4'hA, d, e, lat);
        checks++;
        if (d !== 16'h12AB) begin errors++; $display("FAIL llb got %h required 12ab", d); end
        run_op(16'h7F80, 16'h01FF, 4'h3, d, e, lat);
        checks++;
        if (d !== 16'hFFFF || {flag_z, flag_v, flag_n} !== 3'b011) begin
            errors++; $display("FAIL red got %h zvn=%b%b%b required ffff 011", d, flag_z, flag_v, flag_n);
        end
    endtask

    task automatic test_stall();
        logic [15:0] sa[3], sb[3], want[3];
        logic [3:0]  so[3];
        int          idx, k;
        sa = '{16'h0001, 16'h000A, 16'hF0F0};
        sb = '{16'h0002, 16'h0003, 16'h0FF0};
        so = '{4'h0, 4'h1, 4'h2};
        want = '{16'h0003, 16'h0007, 16'hFF00};
        idx = 0;
        out_ready = 0;
        in_a = sa[0]; in_b = sb[0]; in_op = so[0]; in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (obs_in_hs) idx++;
            if (idx < 3) begin in_a = sa[idx]; in_b = sb[idx]; in_op = so[idx]; end
            else in_valid = 0;
            if (c >= 2) begin
                checks++;
                if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d got %b required 0", c, obs_in_ready); end
            end
            if (obs_out_valid) begin
                checks++;
                if (obs_data !== want[0]) begin errors++; $display("FAIL stall_hold c=%0d got %h required %h", c, obs_data, want[0]); end
            end
            checks++;
            if ({flag_z, flag_v, flag_n} !== {mz, mv, mn}) begin
                errors++; $display("FAIL stall_flags got %b%b%b required %b%b%b", flag_z, flag_v, flag_n, mz, mv, mn);
            end
        end
        checks++;
        if (idx != 2) begin errors++; $display("FAIL stall_accepted got %0d required 2", idx); end
        out_ready = 1;
        k = 0;
        for (int n = 0; n < 20 && k < 3; n++) begin
            step();
            if (obs_in_hs) idx++;
            if (idx < 3) begin in_a = sa[idx]; in_b = sb[idx]; in_op = so[idx]; end
            else in_valid = 0;
            if (obs_out_hs) begin
                checks++;
                if (obs_data !== want[k]) begin errors++; $display("FAIL stall_order k=%0d got %h required %h", k, obs_data, want[k]); end
                k++;
            end
        end
        in_valid = 0;
        checks++;
        if (k != 3) begin errors++; $display("FAIL stall_drain got %0d results required 3", k); end
    endtask

    task automatic test_flush();
        out_ready = 1;
        in_a = 16'h7000; in_b = 16'h2000; in_op = 4'h0; in_valid = 1;
        step();
        in_a = 16'h8000; in_b = 16'h8000;
        step();
        flush = 1; in_a = 16'h1111; in_b = 16'h2222; in_op = 4'h2;
        step();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || {flag_z, flag_v, flag_n} !== 3'b000) begin
            errors++; $display("FAIL flush got v=%b zvn=%b%b%b required 0 000", out_valid, flag_z, flag_v, flag_n);
        end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet n=%0d got %b required 0", n, obs_out_valid); end
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [15:0] d; logic e; int lat;
        run_op(16'h8000, 16'h0001, 4'h1, d, e, lat);
        out_ready = 0;
        in_a = 16'h0001; in_b = 16'h0002; in_op = 4'h2; in_valid = 1;
        for (int n = 0; n < 4; n++) step();
        in_valid = 0;
        rst = 1;
        step();
        checks++;
        if ({out_valid, out_data, out_err, flag_z, flag_v, flag_n} !== 21'h0) begin
            errors++;
            $display("FAIL reset_mid_stall got v=%b d=%h e=%b zvn=%b%b%b required all 0",
                     out_valid, out_data, out_err, flag_z, flag_v, flag_n);
        end
        rst = 0;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_op     = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
            if (obs_out_hs) begin
                checks++;
                if (!exp_avail) begin
                    errors++; $display("FAIL rand_spurious n=%0d got result %h required none", n, obs_data);
                end else if (obs_data !== exp_data || obs_err !== exp_err) begin
                    errors++; $display("FAIL rand_result n=%0d got %h/%b required %h/%b", n, obs_data, obs_err, exp_data, exp_err);
                end
            end
            checks++;
            if ({flag_z, flag_v, flag_n} !== {mz, mv, mn}) begin
                errors++; $display("FAIL rand_flags n=%0d got %b%b%b required %b%b%b", n, flag_z, flag_v, flag_n, mz, mv, mn);
            end
        end
        flush = 0; in_valid = 0; out_ready = 1;
        for (int n = 0; n < 6; n++) begin
            step();
            if (obs_out_hs) begin
                checks++;
                if (!exp_avail || obs_data !== exp_data) begin
                    errors++; $display("FAIL drain_result got %h required %h", obs_data, exp_data);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rand_lost got %0d pending required 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_lanes_shifts();
        test_misc_ops();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
